// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared types and constants for the nibble-serial adder
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // idx register width: clog2 of the nibble count, never narrower than one bit
  function automatic int idx_width(input int nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/add4_slice.sv
// rtl/add4_slice.sv - combinational 4-bit ripple-add slice with carry in/out
module add4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] r;

  assign r       = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};
  assign {co, s} = r;

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder sequenced one nibble per clock
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic              nib_co;

  // Select the current nibble of each captured operand for the shared slice
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_r[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  add4_slice u_slice (
    .x  (nib_a),
    .y  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= nib_s;
          end
          carry <= nib_co;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            c_out <= nib_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for the nibble-serial adder
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rand_go = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Main 16-bit instance
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        start16 = 1'b0, c_in16 = 1'b0, busy16, done16, c_out16;
  logic [16:0] exp16[$];

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(c_in16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(c_out16)
  );

  always @(negedge clk) begin
    logic [16:0] e;
    if (done16) begin
      if (exp16.size() == 0) fail_now("w16 unexpected done");
      else begin
        e = exp16.pop_front();
        chk("w16 result", 64'({c_out16, sum16}), 64'(e));
      end
    end
  end

  task automatic wait_idle16();
    int k = 0;
    while ((busy16 || done16) && k < 30) begin
      @(posedge clk); #1; k++;
    end
    if (busy16 || done16) fail_now("w16 idle timeout");
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    wait_idle16();
    @(posedge clk); #1;
    a16 = av; b16 = bv; c_in16 = cv; start16 = 1'b1;
    exp16.push_back({1'b0, av} + {1'b0, bv} + 17'(cv));
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  // Additional widths exercised with the random back-to-back run
  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int W = (g == 0) ? 4 : 32;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         start = 1'b0, c_in = 1'b0, busy, done, c_out;
    logic         fin = 1'b0;
    logic [W:0]   q[$];

    nibble_serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    always @(negedge clk) begin
      logic [W:0] e;
      if (done) begin
        if (q.size() == 0) fail_now($sformatf("w%0d unexpected done", W));
        else begin
          e = q.pop_front();
          chk($sformatf("w%0d result", W), 64'({c_out, sum}), 64'(e));
        end
      end
    end

    initial begin
      int k, last;
      last = 0;
      wait (rand_go);
      for (int n = 0; n < 200; n++) begin
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c_in));
        start = 1'b1;
        k = 0;
        while ((busy || done) && k < 30) begin @(posedge clk); #1; k++; end
        while (!busy && k < 30) begin @(posedge clk); #1; k++; end
        if (!busy) fail_now($sformatf("w%0d accept timeout", W));
        else if (n > 0) chk($sformatf("w%0d spacing", W), 64'(cyc - last), 64'(W/4 + 2));
        last = cyc;
      end
      start = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 100) begin @(posedge clk); k++; end
      fin = 1'b1;
    end
  end

  initial begin
    int n, k, last;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle outputs", 64'({busy16, done16, c_out16, sum16}), 64'd0);
    end

    // Basic add with exact handshake timing
    wait_idle16();
    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h4321; c_in16 = 1'b0; start16 = 1'b1;
    exp16.push_back(17'h05555);
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("basic busy/done cycle %0d", i), 64'({busy16, done16}),
          (i < 5) ? 64'b10 : 64'b01);
    end

    // Full carry ripple
    issue16(16'hFFFF, 16'h0000, 1'b1);
    issue16(16'h8000, 16'h8000, 1'b0);

    // Start while busy and operand changes during RUN
    issue16(16'h0F0F, 16'h0101, 1'b1);
    #1 start16 = 1'b1; a16 = 16'h1111;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done16) n++;
      if (i == 3) start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); c_in16 = 1'($urandom);
    end
    chk("single done pulse", 64'(n), 64'd1);

    // Reset mid-run
    wait_idle16();
    @(posedge clk); #1;
    a16 = 16'hAAAA; b16 = 16'h5555; c_in16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1 chk("async reset outputs", 64'({busy16, done16, c_out16, sum16}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16) n++;
    end
    chk("no done after abort", 64'(n), 64'd0);
    issue16(16'h0001, 16'h0001, 1'b0);

    // Back-to-back random at all widths
    wait_idle16();
    rand_go = 1'b1;
    last = 0;
    for (int i = 0; i < 200; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c_in16 = 1'($urandom);
      exp16.push_back({1'b0, a16} + {1'b0, b16} + 17'(c_in16));
      start16 = 1'b1;
      k = 0;
      while ((busy16 || done16) && k < 30) begin @(posedge clk); #1; k++; end
      while (!busy16 && k < 30) begin @(posedge clk); #1; k++; end
      if (!busy16) fail_now("w16 accept timeout");
      else if (i > 0) chk("w16 spacing", 64'(cyc - last), 64'd6);
      last = cyc;
    end
    start16 = 1'b0;

    k = 0;
    while ((exp16.size() != 0 || !g_w[0].fin || !g_w[1].fin) && k < 3000) begin
      @(posedge clk); k++;
    end
    if (exp16.size() != 0) fail_now("w16 results outstanding");
    if (g_w[0].q.size() != 0 || !g_w[0].fin) fail_now("w4 results outstanding");
    if (g_w[1].q.size() != 0 || !g_w[1].fin) fail_now("w32 results outstanding");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by reusing one 4-bit ripple-add slice over several cycles.
- Processes one nibble per clock, from the least significant nibble upward, and carries between nibbles in a register.
- Used in the lab datapath where a full-width adder is not wanted: area is traded for latency.
- Host-facing start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on an accepted start.
- b  input  WIDTH  operand B. Captured on an accepted start.
- c_in  input  1  carry-in. Captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- c_out  output  1  final carry. Held the same way as sum.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, c_out=0, internal index=0, carry=0, operand registers=0.
- States:
  - IDLE: waiting for start.
  - RUN: one nibble is added per cycle.
  - DONE: one cycle, then IDLE.
- IDLE, start=1 at edge k:
  - latch a, b and c_in into internal registers; carry reg = c_in; idx = 0; clear sum to 0.
  - go to RUN; busy=1 from cycle k+1.
- RUN, each edge:
  - {carry, sum[4*idx+3:4*idx]} = a_r[idx nibble] + b_r[idx nibble] + carry (5-bit result).
  - idx increments.
  - At the edge that processes idx=NIB-1: c_out = carry result; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next edge goes to IDLE.
- Latency: start sampled at edge k gives done high during cycle k+NIB+1. Default WIDTH=16: done 5 cycles after the start edge.
- sum and c_out are updated nibble by nibble in RUN, so they are not valid until done. After done they are stable until the next accepted start.
- start in RUN or DONE: ignored, with no queuing. Host must wait for IDLE (busy=0 and done=0).
- Changes on a, b or c_in after capture do not affect the running operation.
- Wrap-around: the sum is modulo 2^WIDTH; overflow past the top appears only as c_out=1. Signed overflow is not reported.
- Reset mid-RUN: operation aborted, everything back to reset values, no done pulse.
- Back-to-back: start held high continuously gives one new operation per NIB+2 cycles. It is accepted on the first IDLE cycle after DONE.

Decomposition:
- Shared package nsa_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - NIBBLE_W=4.
  - a function for the idx width, clog2(NIB), minimum 1.
- One sub-module, add4_slice: combinational {co, s[3:0]} = x[3:0] + y[3:0] + ci.
  - Instantiated once; its inputs are driven by nibble multiplexers indexed by idx.
- All state lives in the controller: FSM, idx counter, carry register, operand and sum registers.

Test Plan:
- Reset then idle: rst pulse; start=0 for 10 cycles -> busy=0, done=0, sum=0, c_out=0 throughout.
- Basic add: a=0x1234, b=0x4321, c_in=0, start at edge 0 -> busy high during cycles 1-4; done high only in cycle 5; sum=0x5555, c_out=0.
- Full carry ripple: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1; then a=0x8000, b=0x8000, c_in=0 -> sum=0x0000, c_out=1.
- Start while busy and operand change: start again at cycle 2 with a=0x1111, and change a/b during RUN -> no effect. Result is from the first capture; exactly one done pulse.
- Reset mid-run: assert rst asynchronously during cycle 3 of RUN -> outputs go to 0 immediately, no done pulse. A later start of 0x0001+0x0001 -> sum=0x0002.
- Back-to-back and random: start held high with 200 random a, b, c_in values -> each done matches the reference {c_out,sum}=a+b+c_in. Operations are spaced 6 cycles apart; the same check is repeated with WIDTH=4 and WIDTH=32.
